// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter; LSB first, or MSB first of the effective word when SER_MSB_FIRST_EN is defined.
// Latency: bit 0 registered on D at the accept edge, one bit per cycle after, done one cycle after the last bit.
// Backpressure: load_ready is high only in IDLE; load_valid is ignored while a word is shifting.
module bit_serializer #(
   parameter int WIDTH = 8,
   parameter int LEN_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LEN_W-1:0] load_len,
   output logic             load_ready,
   input  logic             abort,
   output logic             D,
   output logic             d_valid,
   output logic             done
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t           state_q;
   logic [WIDTH-1:0] sr_q;
   logic [LEN_W-1:0] cnt_q;
   logic             d_q;
   logic             vld_q;
   logic             done_q;

   logic [LEN_W-1:0] len_d;
   logic             first_bit_d;
   logic [WIDTH-1:0] sr_load_d;
   logic             next_bit_d;
   logic [WIDTH-1:0] sr_next_d;

   // Zero and out-of-range lengths both mean a full-width word.
   always_comb begin
      len_d = load_len;
      if ((load_len == '0) || (load_len > LEN_MAX)) begin
         len_d = LEN_MAX;
      end
   end

`ifdef SER_MSB_FIRST_EN
   logic [WIDTH-1:0] word_aligned_d;

   // Left-align the effective word so its top bit always sits at WIDTH-1.
   always_comb begin
      word_aligned_d = load_data << (LEN_MAX - len_d);
      first_bit_d    = word_aligned_d[WIDTH-1];
      sr_load_d      = word_aligned_d << 1;
      next_bit_d     = sr_q[WIDTH-1];
      sr_next_d      = sr_q << 1;
   end
`else
   always_comb begin
      first_bit_d = load_data[0];
      sr_load_d   = load_data >> 1;
      next_bit_d  = sr_q[0];
      sr_next_d   = sr_q >> 1;
   end
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         d_q     <= 1'b0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (load_valid) begin
                  state_q <= SHIFT;
                  sr_q    <= sr_load_d;
                  cnt_q   <= len_d;
                  d_q     <= first_bit_d;
                  vld_q   <= 1'b1;
               end
            end
            SHIFT: begin
               // Abort wins over the last-bit transition and suppresses done.
               if (abort) begin
                  state_q <= IDLE;
                  sr_q    <= '0;
                  cnt_q   <= '0;
                  d_q     <= 1'b0;
                  vld_q   <= 1'b0;
                  done_q  <= 1'b0;
               end else if (cnt_q == LEN_ONE) begin
                  state_q <= IDLE;
                  sr_q    <= '0;
                  cnt_q   <= '0;
                  d_q     <= 1'b0;
                  vld_q   <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  sr_q  <= sr_next_d;
                  cnt_q <= cnt_q - LEN_ONE;
                  d_q   <= next_bit_d;
               end
            end
            default: begin
               state_q <= IDLE;
               sr_q    <= '0;
               cnt_q   <= '0;
               d_q     <= 1'b0;
               vld_q   <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign load_ready = (state_q == IDLE);
   assign D          = d_q;
   assign d_valid    = vld_q;
   assign done       = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: queue-based bit model compared every cycle, plus directed literal checks.
// Latency: model mirrors the accept-edge timing of the serializer.
// Backpressure: stimulus waits on load_ready with a bounded cycle budget.
`timescale 1ns/1ps
module tb_bit_serializer;
   localparam int WIDTH = 8;
   localparam int LEN_W = $clog2(WIDTH + 1);

`ifdef SER_MSB_FIRST_EN
   localparam logic [31:0] EXP_B4 = 32'hB4;
   localparam logic [31:0] EXP_3C = 32'h3C;
   localparam logic [31:0] EXP_C1 = 32'hC1;
`else
   localparam logic [31:0] EXP_B4 = 32'h2D;
   localparam logic [31:0] EXP_3C = 32'h0F;
   localparam logic [31:0] EXP_C1 = 32'h83;
`endif

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             load_valid = 1'b0;
   logic [WIDTH-1:0] load_data = '0;
   logic [LEN_W-1:0] load_len = '0;
   logic             abort = 1'b0;
   logic             load_ready;
   logic             D;
   logic             d_valid;
   logic             done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_len   (load_len),
      .load_ready (load_ready),
      .abort      (abort),
      .D          (D),
      .d_valid    (d_valid),
      .done       (done)
   );

   // Model: queue of bits still to be shown; the head is the bit on D now.
   bit m_q[$];
   bit m_done;

   function automatic void m_load(input logic [WIDTH-1:0] data, input logic [LEN_W-1:0] len);
      int n;
      n = ((len == 0) || (int'(len) > WIDTH)) ? WIDTH : int'(len);
      m_q.delete();
      for (int i = 0; i < n; i++) begin
`ifdef SER_MSB_FIRST_EN
         m_q.push_back(data[n-1-i]);
`else
         m_q.push_back(data[i]);
`endif
      end
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_q.delete();
         m_done = 1'b0;
      end else if (m_q.size() != 0) begin
         m_done = 1'b0;
         if (abort) begin
            m_q.delete();
         end else begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_done = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (load_valid) m_load(load_data, load_len);
      end
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic exp_d;
      exp_d = (m_q.size() != 0) ? m_q[0] : 1'b0;
      chk("model_D", D, exp_d);
      chk("model_d_valid", d_valid, m_q.size() != 0);
      chk("model_done", done, m_done);
      chk("model_load_ready", load_ready, m_q.size() == 0);
   end

   // Called at posedge+1; returns at posedge+1 of cycle 1 after the accept edge.
   task automatic load_word(input logic [WIDTH-1:0] data, input logic [LEN_W-1:0] len);
      int n;
      n = 0;
      while (!load_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!load_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout t=%0t", $time);
      end
      load_data  = data;
      load_len   = len;
      load_valid = 1'b1;
      @(posedge clk); #1;
      load_valid = 1'b0;
   endtask

   task automatic observe(input int ncyc, output logic [31:0] seq, output int nvalid,
                          output int done_cyc, output int ndone, output int rdy_low);
      seq = '0; nvalid = 0; done_cyc = 0; ndone = 0; rdy_low = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (d_valid) begin
            seq = {seq[30:0], D};
            nvalid++;
         end
         if (done) begin
            ndone++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (!load_ready) rdy_low++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] seq;
      int nvalid, done_cyc, ndone, rdy_low;
      logic vld_hist[1:20];

      // Reset held for two cycles
      repeat (2) begin
         @(negedge clk);
         chk("rst_D", D, 1'b0);
         chk("rst_d_valid", d_valid, 1'b0);
         chk("rst_done", done, 1'b0);
         chk("rst_load_ready", load_ready, 1'b1);
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("post_rst_d_valid", d_valid, 1'b0);
      chk("post_rst_load_ready", load_ready, 1'b1);
      @(posedge clk); #1;

      // Full-width word via len=0
      load_word(8'hB4, 0);
      observe(12, seq, nvalid, done_cyc, ndone, rdy_low);
      chk_int("b4_seq", int'(seq), int'(EXP_B4));
      chk_int("b4_nvalid", nvalid, 8);
      chk_int("b4_done_cyc", done_cyc, 9);
      chk_int("b4_ndone", ndone, 1);
      chk_int("b4_ready_low", rdy_low, 8);

      // Short word
      load_word(8'h05, 3);
      observe(6, seq, nvalid, done_cyc, ndone, rdy_low);
      chk_int("w05_seq", int'(seq), 5);
      chk_int("w05_nvalid", nvalid, 3);
      chk_int("w05_done_cyc", done_cyc, 4);

      // Single-bit word and an out-of-range length
      load_word(8'h01, 1);
      observe(4, seq, nvalid, done_cyc, ndone, rdy_low);
      chk_int("len1_seq", int'(seq), 1);
      chk_int("len1_done_cyc", done_cyc, 2);
      load_word(8'hB4, 4'd9);
      observe(11, seq, nvalid, done_cyc, ndone, rdy_low);
      chk_int("len9_seq", int'(seq), int'(EXP_B4));
      chk_int("len9_nvalid", nvalid, 8);

      // Back-to-back with load_valid held high
      load_data  = 8'h96;
      load_len   = 0;
      load_valid = 1'b1;
      @(posedge clk); #1;
      load_data = 8'hC1;
      seq = '0; nvalid = 0; done_cyc = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         vld_hist[c] = d_valid;
         if (d_valid && c <= 17) nvalid++;
         if (d_valid && c >= 10 && c <= 17) seq = {seq[30:0], D};
         if (done && done_cyc == 0) done_cyc = c;
         @(posedge clk); #1;
         if (c == 9) load_valid = 1'b0;
      end
      chk_int("b2b_done_cyc", done_cyc, 9);
      chk("b2b_vld_c8", vld_hist[8], 1'b1);
      chk("b2b_vld_c9", vld_hist[9], 1'b0);
      chk("b2b_vld_c10", vld_hist[10], 1'b1);
      chk("b2b_vld_c18", vld_hist[18], 1'b0);
      chk_int("b2b_nvalid", nvalid, 16);
      chk_int("b2b_second_seq", int'(seq), int'(EXP_C1));

      // Abort during bit 3
      load_word(8'hFF, 0);
      repeat (3) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_d_valid", d_valid, 1'b0);
      chk("abort_D", D, 1'b0);
      observe(10, seq, nvalid, done_cyc, ndone, rdy_low);
      chk_int("abort_ndone", ndone, 0);
      chk_int("abort_rdy_low", rdy_low, 0);
      load_word(8'h3C, 6);
      observe(9, seq, nvalid, done_cyc, ndone, rdy_low);
      chk_int("post_abort_seq", int'(seq), int'(EXP_3C));
      chk_int("post_abort_nvalid", nvalid, 6);
      chk_int("post_abort_done_cyc", done_cyc, 7);

      // Asynchronous reset during bit 5
      load_word(WIDTH'($urandom), 0);
      repeat (5) begin @(posedge clk); #1; end
      @(negedge clk); #2;
      rstn = 1'b0;
      #1;
      chk("arst_D", D, 1'b0);
      chk("arst_d_valid", d_valid, 1'b0);
      chk("arst_done", done, 1'b0);
      chk("arst_load_ready", load_ready, 1'b1);
      @(negedge clk); #2;
      rstn = 1'b1;
      @(posedge clk); #1;
      observe(10, seq, nvalid, done_cyc, ndone, rdy_low);
      chk_int("arst_ndone", ndone, 0);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         load_valid = ($urandom_range(0, 3) != 0);
         load_data  = WIDTH'($urandom);
         load_len   = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
         abort      = ($urandom_range(0, 19) == 0);
         @(posedge clk); #1;
      end
      load_valid = 1'b0;
      abort      = 1'b0;
      repeat (WIDTH + 4) begin @(posedge clk); #1; end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial transmitter that produces the single-bit `D` stream consumed by the `DFF` capture stage and its downstream logic. It accepts a word of up to `WIDTH` bits through a valid/ready load handshake and shifts the word out one bit per `clk` cycle with a qualifying valid strobe. A one-cycle completion pulse marks the end of each word. The block replaces hand-timed `D` stimulus with a synthesizable, cycle-exact source.

## Interface
- `WIDTH`, 8: maximum word length in bits; legal range 2..32.
- `LEN_W`, `$clog2(WIDTH+1)`: width of `load_len`.

- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  load request; `load_data`/`load_len` are valid while it is high.
- `load_data`  in  WIDTH  word to transmit.
- `load_len`  in  LEN_W  number of bits to send; 0 and values >WIDTH mean WIDTH.
- `load_ready`  out  1  high only in IDLE; a load is accepted on an edge where `load_valid && load_ready`.
- `abort`  in  1  synchronous cancel of the word in flight.
- `D`  out  1  serial data bit, registered.
- `d_valid`  out  1  high while `D` carries a payload bit, registered.
- `done`  out  1  single-cycle pulse after the last bit of a word, registered.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: `load_ready`=1, `D`=0, `d_valid`=0. On accept:
  - capture `load_data` into the shift register;
  - set the bit counter to the effective length;
  - drive the first bit on `D`, set `d_valid`=1;
  - go to SHIFT.
- SHIFT: on each edge, advance to the next bit and decrement the counter.
  - On the edge where the counter is 1 (last bit was shown), go to IDLE with `D`=0, `d_valid`=0, and `done`=1 for one cycle.
- `load_valid` is ignored in SHIFT. No load is accepted in the same cycle that `done` is high; `load_ready` rises together with `done`.
- Bit order without the macro: LSB first (`load_data[0]`, `[1]`, …, `[len-1]`). Bits above `len-1` are never transmitted.
- `abort` is sampled in SHIFT only: the next edge goes to IDLE with `D`=0 and `d_valid`=0, and `done` is not asserted. `abort` is ignored in IDLE and takes priority over the last-bit transition.
- `D` is 0 whenever `d_valid` is 0.

## Timing
- Reset (`rstn`=0, any time, asynchronous):
  - state IDLE;
  - `D`=0, `d_valid`=0, `done`=0, `load_ready`=1;
  - shift register and counter cleared.
- Reset mid-word drops the word with no `done`.
- Latency: accept at edge k gives bit 0 on `D` from edge k through edge k+1, and bit i from edge k+i.
- `d_valid` is high for exactly `len` cycles, `done` is high in cycle k+len, and the next accept is possible at edge k+len+1.
- Word throughput: `len`+1 cycles per word.
- `load_ready` is a decode of the state register, with no combinational path from `load_valid`.

## Configuration
- `SER_MSB_FIRST_EN`:
  - Defined: transmit MSB of the effective word first (`load_data[len-1]` down to `load_data[0]`).
  - Undefined: LSB first.
- Latency, handshake and length handling are identical in both builds.

## Test plan
- Reset check: hold `rstn`=0 for 2 cycles, then release. Required: `D`=0, `d_valid`=0, `done`=0 and `load_ready`=1 during and after reset.
- LSB-first word (macro undefined): load `8'hB4` with `len`=0. Required:
  - `D` sequence 0,0,1,0,1,1,0,1 with `d_valid` high for 8 cycles;
  - `done` pulse in cycle 9;
  - `load_ready` low for cycles 1–8.
- Short word, MSB-first build: load `8'h05` with `len`=3. Required: `D`=1,0,1 for 3 cycles, then `done`, and `D` back to 0.
- Back-to-back traffic: hold `load_valid`=1 with a new word. Required:
  - `load_valid` is ignored during SHIFT;
  - the second word is accepted on the first edge after `done`;
  - exactly one idle cycle separates the two words.
- Abort: load `8'hFF` and assert `abort` during bit 3. Required:
  - `d_valid` falls on the next edge;
  - `done` never asserts;
  - `load_ready`=1 and a following word transmits correctly.
- Asynchronous reset mid-word: drive `rstn` low between edges during bit 5. Required: outputs clear immediately without waiting for `clk`, and no `done` is produced.
